// File: rtl/desnorm_deslin_scheduler.sv
// desnorm_deslin_scheduler
// Sequencing controller for the denormalizer/delinearizer datapath.
// Accepts one I/V operand pair, pulses Begin to both channels, waits for a
// rising ACK on each channel, then holds the result pair on a valid/ready
// output. One operation is in flight at a time.
// Optional feature macro: ACK_TIMEOUT_EN (bounded WAIT with TIMEOUT_ERR pulse).
module desnorm_deslin_scheduler #(
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         SAMPLE_VALID,
  output logic         SAMPLE_READY,
  input  logic [W-1:0] I_IN,
  input  logic [W-1:0] V_IN,
  output logic         BEGIN_FSM_I,
  output logic         BEGIN_FSM_V,
  output logic [W-1:0] I_OP,
  output logic [W-1:0] V_OP,
  input  logic         ACK_I,
  input  logic         ACK_V,
  input  logic [W-1:0] RESULT_I,
  input  logic [W-1:0] RESULT_V,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT_I,
  output logic [W-1:0] OUT_V,
  output logic         BUSY,
  output logic         TIMEOUT_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] i_op_q, i_op_d;
  logic [W-1:0] v_op_q, v_op_d;
  logic [W-1:0] out_i_q, out_i_d;
  logic [W-1:0] out_v_q, out_v_d;
  logic         ack_i_q, ack_v_q;
  logic         di_q, di_d;
  logic         dv_q, dv_d;
  logic         rise_i, rise_v;
  logic         done_w;
  logic         abort_w;

  // Only a fresh rising edge counts; levels left over from an earlier
  // operation are filtered because ack_x_q tracks the line every cycle.
  assign rise_i = ACK_I & ~ack_i_q;
  assign rise_v = ACK_V & ~ack_v_q;
  assign done_w = (di_q | rise_i) & (dv_q | rise_v);

`ifdef ACK_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // WAIT cycle counter: cleared on launch, counts every cycle spent waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Completion in the same cycle as the limit takes priority over abort.
  assign abort_w = (state_q == ST_WAIT) && (cnt_d == TIMEOUT_V) && !done_w;
  assign err_d   = abort_w;

  // Counter and one-cycle abort pulse registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign TIMEOUT_ERR = err_q;
`else
  // Unbounded WAIT: no counter, the abort path never fires.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
  assign abort_w     = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  // Next-state, operand capture, done flags and result capture.
  always_comb begin
    state_d = state_q;
    i_op_d  = i_op_q;
    v_op_d  = v_op_q;
    out_i_d = out_i_q;
    out_v_d = out_v_q;
    di_d    = di_q;
    dv_d    = dv_q;
    case (state_q)
      ST_IDLE: begin
        if (SAMPLE_VALID) begin
          i_op_d  = I_IN;
          v_op_d  = V_IN;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        di_d    = 1'b0;
        dv_d    = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        di_d = di_q | rise_i;
        dv_d = dv_q | rise_v;
        if (done_w) begin
          out_i_d = RESULT_I;
          out_v_d = RESULT_V;
          state_d = ST_HOLD;
        end else if (abort_w) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single state register block; reset discards any in-flight sample.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      i_op_q  <= '0;
      v_op_q  <= '0;
      out_i_q <= '0;
      out_v_q <= '0;
      ack_i_q <= 1'b0;
      ack_v_q <= 1'b0;
      di_q    <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_op_q  <= i_op_d;
      v_op_q  <= v_op_d;
      out_i_q <= out_i_d;
      out_v_q <= out_v_d;
      ack_i_q <= ACK_I;
      ack_v_q <= ACK_V;
      di_q    <= di_d;
      dv_q    <= dv_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  assign SAMPLE_READY = (state_q == ST_IDLE);
  assign BUSY         = (state_q != ST_IDLE);
  assign BEGIN_FSM_I  = (state_q == ST_LAUNCH);
  assign BEGIN_FSM_V  = (state_q == ST_LAUNCH);
  assign OUT_VALID    = (state_q == ST_HOLD);
  assign I_OP         = i_op_q;
  assign V_OP         = v_op_q;
  assign OUT_I        = out_i_q;
  assign OUT_V        = out_v_q;

endmodule

// File: tb/tb_desnorm_deslin_scheduler.sv
// Directed testbench for desnorm_deslin_scheduler.
// Build with +define+ACK_TIMEOUT_EN to exercise the timeout abort path.
module tb_desnorm_deslin_scheduler;

  localparam int W = 32;

  logic         CLK;
  logic         RST_N;
  logic         SAMPLE_VALID;
  logic         SAMPLE_READY;
  logic [W-1:0] I_IN, V_IN;
  logic         BEGIN_FSM_I, BEGIN_FSM_V;
  logic [W-1:0] I_OP, V_OP;
  logic         ACK_I, ACK_V;
  logic [W-1:0] RESULT_I, RESULT_V;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] OUT_I, OUT_V;
  logic         BUSY;
  logic         TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;

  desnorm_deslin_scheduler #(.W(W), .TIMEOUT(16)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_READY (SAMPLE_READY),
    .I_IN         (I_IN),
    .V_IN         (V_IN),
    .BEGIN_FSM_I  (BEGIN_FSM_I),
    .BEGIN_FSM_V  (BEGIN_FSM_V),
    .I_OP         (I_OP),
    .V_OP         (V_OP),
    .ACK_I        (ACK_I),
    .ACK_V        (ACK_V),
    .RESULT_I     (RESULT_I),
    .RESULT_V     (RESULT_V),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .OUT_I        (OUT_I),
    .OUT_V        (OUT_V),
    .BUSY         (BUSY),
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    RST_N        = 1'b0;
    SAMPLE_VALID = 1'b0;
    I_IN         = '0;
    V_IN         = '0;
    ACK_I        = 1'b0;
    ACK_V        = 1'b0;
    RESULT_I     = '0;
    RESULT_V     = '0;
    OUT_READY    = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_ready", SAMPLE_READY, 1);
    check("rst_busy", BUSY, 0);
    check("rst_begin", {BEGIN_FSM_I, BEGIN_FSM_V}, 0);
    check("rst_valid", OUT_VALID, 0);
    check("rst_terr", TIMEOUT_ERR, 0);
    check("rst_ops", {I_OP, V_OP}, 0);
    check("rst_outs", {OUT_I, OUT_V}, 0);
    RST_N = 1'b1;
    step();

    // Basic operation: accept at edge t, ACKs rise in cycle t+3
    SAMPLE_VALID = 1'b1;
    I_IN = 32'hfd28e4fa;
    V_IN = 32'hb0bcee61;
    check("basic_ready_idle", SAMPLE_READY, 1);
    step();                                   // cycle t+1
    SAMPLE_VALID = 1'b0;
    check("basic_begin", {BEGIN_FSM_I, BEGIN_FSM_V}, 2'b11);
    check("basic_busy", BUSY, 1);
    check("basic_ready_launch", SAMPLE_READY, 0);
    check("basic_i_op", I_OP, 32'hfd28e4fa);
    check("basic_v_op", V_OP, 32'hb0bcee61);
    step();                                   // cycle t+2
    check("basic_begin_once", {BEGIN_FSM_I, BEGIN_FSM_V}, 2'b00);
    step();                                   // cycle t+3
    ACK_I = 1'b1; ACK_V = 1'b1;
    RESULT_I = 32'h1; RESULT_V = 32'h2;
    check("basic_valid_early", OUT_VALID, 0);
    step();                                   // cycle t+4
    check("basic_valid", OUT_VALID, 1);
    check("basic_out", {OUT_I, OUT_V}, {32'h1, 32'h2});
    check("basic_op_stable", {I_OP, V_OP}, {32'hfd28e4fa, 32'hb0bcee61});
    RESULT_I = 32'hdead;
    step();
    check("basic_out_hold", OUT_I, 32'h1);
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check("basic_done_valid", OUT_VALID, 0);
    check("basic_done_ready", SAMPLE_READY, 1);
    ACK_I = 1'b0; ACK_V = 1'b0;
    $display("txn basic I_OP=fd28e4fa V_OP=b0bcee61 -> OUT_I=1 OUT_V=2");

    // Minimum latency: ACKs rise in the first WAIT cycle
    SAMPLE_VALID = 1'b1;
    I_IN = 32'h0000_0abc; V_IN = 32'h0000_0def;
    step();                                   // LAUNCH
    SAMPLE_VALID = 1'b0;
    step();                                   // first WAIT cycle
    ACK_I = 1'b1; ACK_V = 1'b1;
    RESULT_I = 32'h11; RESULT_V = 32'h22;
    step();
    check("minlat_valid", OUT_VALID, 1);
    check("minlat_out", {OUT_I, OUT_V}, {32'h11, 32'h22});
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    $display("txn minlat -> OUT_I=11 OUT_V=22");

    // Stale ACK_I: held high before launch, only a fresh rise completes
    ACK_V = 1'b0;
    SAMPLE_VALID = 1'b1;
    step();                                   // LAUNCH
    SAMPLE_VALID = 1'b0;
    step();                                   // WAIT
    repeat (10) step();
    ACK_V = 1'b1;
    RESULT_I = 32'h33; RESULT_V = 32'h44;
    step();
    check("stale_no_done", OUT_VALID, 0);
    repeat (3) step();
    check("stale_busy", BUSY, 1);
    check("stale_still_wait", OUT_VALID, 0);
    ACK_I = 1'b0;
    step();
    check("stale_fall_ignored", OUT_VALID, 0);
    ACK_I = 1'b1;
    step();
    check("stale_valid", OUT_VALID, 1);
    check("stale_out", {OUT_I, OUT_V}, {32'h33, 32'h44});
    $display("txn stale_ack -> OUT_I=33 OUT_V=44");

    // Back-pressure: 20 stalled cycles with a new sample pending
    SAMPLE_VALID = 1'b1;
    I_IN = 32'h55; V_IN = 32'h66;
    RESULT_I = 32'h77;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_flags", {OUT_VALID, SAMPLE_READY}, 2'b10);
      check("bp_out", {OUT_I, OUT_V}, {32'h33, 32'h44});
    end
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check("bp_release_ready", SAMPLE_READY, 1);
    check("bp_release_valid", OUT_VALID, 0);
    step();                                   // pending sample accepted
    SAMPLE_VALID = 1'b0;
    check("bp_next_begin", BEGIN_FSM_I, 1);
    check("bp_next_op", {I_OP, V_OP}, {32'h55, 32'h66});
    $display("txn backpressure -> 20 stall cycles, next I_OP=55 V_OP=66");

    // Falling edges ignored; I completes before V
    step();                                   // WAIT
    ACK_I = 1'b0; ACK_V = 1'b0;
    step();
    check("fall_no_done", OUT_VALID, 0);
    ACK_I = 1'b1;
    RESULT_I = 32'h88; RESULT_V = 32'h99;
    step();
    check("i_first_no_done", OUT_VALID, 0);
    ACK_V = 1'b1;
    step();
    check("i_first_valid", OUT_VALID, 1);
    check("i_first_out", {OUT_I, OUT_V}, {32'h88, 32'h99});
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    ACK_I = 1'b0; ACK_V = 1'b0;
    $display("txn i_first -> OUT_I=88 OUT_V=99");

    // WAIT bound behaviour; ACK_V never rises
    SAMPLE_VALID = 1'b1;
    I_IN = 32'h1234; V_IN = 32'h5678;
    step();                                   // LAUNCH
    SAMPLE_VALID = 1'b0;
    step();                                   // WAIT cycle 1
    ACK_I = 1'b1;
`ifdef ACK_TIMEOUT_EN
    repeat (15) step();                       // WAIT cycle 16
    check("to_busy_last", BUSY, 1);
    check("to_no_err_yet", TIMEOUT_ERR, 0);
    step();
    check("to_err", TIMEOUT_ERR, 1);
    check("to_idle", BUSY, 0);
    check("to_no_valid", OUT_VALID, 0);
    step();
    check("to_err_pulse", TIMEOUT_ERR, 0);
    check("to_no_valid_after", OUT_VALID, 0);
    $display("txn timeout -> aborted after 16 WAIT cycles");
    ACK_I = 1'b0;
    SAMPLE_VALID = 1'b1;
    step();                                   // LAUNCH
    SAMPLE_VALID = 1'b0;
    step();                                   // WAIT
`else
    repeat (30) step();
    check("nobound_busy", BUSY, 1);
    check("nobound_terr", TIMEOUT_ERR, 0);
    check("nobound_valid", OUT_VALID, 0);
    ACK_I = 1'b0;
    step();
    $display("txn unbounded wait -> still waiting after 31 cycles");
`endif

    // Reset mid-WAIT: outputs return to reset values immediately
    RST_N = 1'b0;
    #1;
    check("midrst_ready", SAMPLE_READY, 1);
    check("midrst_busy", BUSY, 0);
    check("midrst_valid", OUT_VALID, 0);
    check("midrst_ops", {I_OP, V_OP}, 0);
    check("midrst_outs", {OUT_I, OUT_V}, 0);
    step();
    RST_N = 1'b1;
    step();
    ACK_I = 1'b1; ACK_V = 1'b1;
    RESULT_I = 32'haa; RESULT_V = 32'hbb;
    step();
    step();
    check("midrst_discard", {OUT_VALID, BUSY}, 2'b00);
    $display("txn reset mid-wait -> sample discarded");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
